// File: rtl/hps_mailbox_pkg.sv
// Shared constants for the HPS stream mailbox: register addresses and bit positions.
package hps_mailbox_pkg;

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned THRESH_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_TXDATA = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_RXDATA = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_LEVEL  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_THRESH = 3'd5;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_FULL  = 2;
  localparam int unsigned ST_RX_EMPTY = 3;
  localparam int unsigned ST_TX_OVF   = 4;
  localparam int unsigned ST_RX_UDF   = 5;
  localparam int unsigned ST_IRQ      = 6;

  localparam int unsigned CTRL_IRQ_EN   = 0;
  localparam int unsigned CTRL_TX_FLUSH = 1;
  localparam int unsigned CTRL_RX_FLUSH = 2;

endpackage

// File: rtl/mailbox_sync_fifo.sv
// Single-clock show-ahead FIFO; flush beats push/pop, push on full succeeds only with a pop.
module mailbox_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok_c, push_ok_c;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign pop_ok_c  = pop_i && !empty_o;
  assign push_ok_c = push_i && (!full_o || pop_ok_c);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok_c) - CW'(pop_ok_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok_c && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/hps_stream_mailbox.sv
// Avalon-MM word mailbox between the HPS bridge and fabric valid/ready streams.
module hps_stream_mailbox
  import hps_mailbox_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

  logic [TX_CW-1:0]    tx_count;
  logic [RX_CW-1:0]    rx_count;
  logic [DATA_W-1:0]   rx_head;
  logic                tx_full, tx_empty, rx_full, rx_empty;

  logic                irq_en_q, irq_en_d;
  logic [THRESH_W-1:0] thresh_q, thresh_d;
  logic                tx_ovf_q, tx_ovf_d;
  logic                rx_udf_q, rx_udf_d;
  logic [31:0]         readdata_q, readdata_d;
  logic                irq_q, irq_d;

  logic                wr_tx_c, rd_rx_c, tx_pop_c, rx_push_c, rx_pop_c;
  logic                tx_flush_c, rx_flush_c, irq_raw_c;
  logic [31:0]         status_c;

  assign wr_tx_c    = avs_write && (avs_address == ADDR_TXDATA);
  assign rd_rx_c    = avs_read  && (avs_address == ADDR_RXDATA);
  assign tx_flush_c = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[CTRL_TX_FLUSH];
  assign rx_flush_c = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[CTRL_RX_FLUSH];
  assign tx_pop_c   = tx_valid && tx_ready;
  assign rx_push_c  = rx_valid && rx_ready;
  assign rx_pop_c   = rd_rx_c && !rx_empty;

  mailbox_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push_i  (wr_tx_c),
    .pop_i   (tx_pop_c),
    .flush_i (tx_flush_c),
    .data_i  (avs_writedata[DATA_W-1:0]),
    .head_o  (tx_data),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  mailbox_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push_i  (rx_push_c),
    .pop_i   (rx_pop_c),
    .flush_i (rx_flush_c),
    .data_i  (rx_data),
    .head_o  (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  // Level term is ignored while THRESH is zero.
  assign irq_raw_c = ((thresh_q != '0) && (32'(rx_count) >= 32'(thresh_q)))
                     || tx_ovf_q || rx_udf_q;

  always_comb begin
    status_c              = '0;
    status_c[ST_TX_FULL]  = tx_full;
    status_c[ST_TX_EMPTY] = tx_empty;
    status_c[ST_RX_FULL]  = rx_full;
    status_c[ST_RX_EMPTY] = rx_empty;
    status_c[ST_TX_OVF]   = tx_ovf_q;
    status_c[ST_RX_UDF]   = rx_udf_q;
    status_c[ST_IRQ]      = irq_raw_c;
  end

  always_comb begin
    irq_en_d   = irq_en_q;
    thresh_d   = thresh_q;
    tx_ovf_d   = tx_ovf_q;
    rx_udf_d   = rx_udf_q;
    readdata_d = '0;
    irq_d      = irq_en_q && irq_raw_c;

    if (wr_tx_c && tx_full && !tx_pop_c && !tx_flush_c) tx_ovf_d = 1'b1;
    if (rd_rx_c && rx_empty && !rx_flush_c)             rx_udf_d = 1'b1;

    if (avs_write) begin
      unique case (avs_address)
        ADDR_STATUS: begin
          if (avs_writedata[ST_TX_OVF]) tx_ovf_d = 1'b0;
          if (avs_writedata[ST_RX_UDF]) rx_udf_d = 1'b0;
        end
        ADDR_CTRL:   irq_en_d = avs_writedata[CTRL_IRQ_EN];
        ADDR_THRESH: thresh_d = avs_writedata[THRESH_W-1:0];
        default: ;
      endcase
    end

    if (avs_read) begin
      unique case (avs_address)
        ADDR_RXDATA: readdata_d = 32'(rx_head);
        ADDR_STATUS: readdata_d = status_c;
        ADDR_LEVEL:  readdata_d = {16'(rx_count), 16'(tx_count)};
        ADDR_CTRL:   readdata_d = 32'(irq_en_q);
        ADDR_THRESH: readdata_d = 32'(thresh_q);
        default:     readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_en_q   <= 1'b0;
      thresh_q   <= '0;
      tx_ovf_q   <= 1'b0;
      rx_udf_q   <= 1'b0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      thresh_q   <= thresh_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_udf_q   <= rx_udf_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_hps_stream_mailbox.sv
// Scenario bench for hps_stream_mailbox with TX/RX expectation queues.
module tb_hps_stream_mailbox;

  localparam int unsigned DATA_W = 32;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n = 1'b0;
  logic [2:0]        avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic [31:0]       avs_readdata;
  logic              irq;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;

  int errors = 0;
  int checks = 0;
  logic [31:0] tx_exp[$];
  logic [31:0] rx_exp[$];

  hps_stream_mailbox #(.DATA_W(DATA_W), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready)
  );

  always #5 clk_clk = ~clk_clk;

  // Bus drivers; all tasks start and end 1 time unit after a rising edge.
  task automatic avs_wr(input logic [2:0] addr, input logic [31:0] data);
    avs_address = addr; avs_writedata = data; avs_write = 1'b1;
    @(posedge clk_clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [2:0] addr, output logic [31:0] data);
    avs_address = addr; avs_read = 1'b1;
    @(posedge clk_clk); #1;
    avs_read = 1'b0;
    data = avs_readdata;
  endtask

  task automatic cycle();
    @(posedge clk_clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    cycle();
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", avs_readdata); end
    checks++; if ({irq, tx_valid, rx_ready} !== 3'b001) begin errors++; $display("FAIL reset_outputs irq/tx_valid/rx_ready got=%b exp=001", {irq, tx_valid, rx_ready}); end
    checks++; if (tx_data !== '0) begin errors++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
    avs_rd(3'd2, rd);
    checks++; if (rd !== 32'h0A) begin errors++; $display("FAIL reset_status got=%h exp=0000000a", rd); end
    avs_rd(3'd5, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_thresh got=%h exp=0", rd); end
  endtask

  task automatic test_tx_basic();
    logic [31:0] rd, exp;
    tx_ready = 1'b0;
    avs_wr(3'd0, 32'hA5); tx_exp.push_back(32'hA5);
    checks++; if (tx_valid !== 1'b1 || tx_data !== tx_exp[0]) begin errors++; $display("FAIL tx_first_word valid=%b data=%h exp valid=1 data=%h", tx_valid, tx_data, tx_exp[0]); end
    avs_rd(3'd3, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL tx_level_one got=%h exp=00000001", rd); end
    tx_ready = 1'b1;
    @(negedge clk_clk);
    exp = tx_exp.pop_front();
    checks++; if (tx_valid !== 1'b1 || tx_data !== exp) begin errors++; $display("FAIL tx_pop_data valid=%b data=%h exp=%h", tx_valid, tx_data, exp); end
    cycle();
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_valid_after_pop got=%b exp=0", tx_valid); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] rd;
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      avs_wr(3'd0, 32'h100 + 32'(i));
      if (i < 16) tx_exp.push_back(32'h100 + 32'(i));
    end
    avs_rd(3'd3, rd);
    checks++; if (rd !== 32'h10) begin errors++; $display("FAIL tx_level_full got=%h exp=00000010", rd); end
    avs_rd(3'd2, rd);
    checks++; if (rd !== 32'h59) begin errors++; $display("FAIL tx_ovf_status got=%h exp=00000059", rd); end
    avs_wr(3'd2, 32'h10);
    avs_rd(3'd2, rd);
    checks++; if (rd !== 32'h09) begin errors++; $display("FAIL tx_ovf_clear got=%h exp=00000009", rd); end
  endtask

  task automatic test_full_pushpop_flush();
    logic [31:0] rd, exp;
    avs_address = 3'd0; avs_writedata = 32'h777; avs_write = 1'b1; tx_ready = 1'b1;
    @(negedge clk_clk);
    exp = tx_exp.pop_front();
    checks++; if (tx_data !== exp) begin errors++; $display("FAIL full_pushpop_head got=%h exp=%h", tx_data, exp); end
    cycle();
    avs_write = 1'b0; tx_ready = 1'b0;
    tx_exp.push_back(32'h777);
    avs_rd(3'd2, rd);
    checks++; if (rd !== 32'h09) begin errors++; $display("FAIL full_pushpop_status got=%h exp=00000009", rd); end
    avs_rd(3'd3, rd);
    checks++; if (rd !== 32'h10) begin errors++; $display("FAIL full_pushpop_level got=%h exp=00000010", rd); end
    rx_data = 32'h55; rx_valid = 1'b1; rx_exp.push_back(32'h55);
    avs_wr(3'd4, 32'h2);
    rx_valid = 1'b0;
    tx_exp.delete();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL flush_tx_valid got=%b exp=0", tx_valid); end
    avs_rd(3'd3, rd);
    checks++; if (rd !== 32'h0001_0000) begin errors++; $display("FAIL flush_level got=%h exp=00010000", rd); end
    avs_rd(3'd4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL flush_ctrl_readback got=%h exp=0", rd); end
    avs_rd(3'd1, rd);
    exp = rx_exp.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL flush_rx_kept got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_rx_fill();
    logic [31:0] rd, exp;
    for (int i = 1; i <= 16; i++) begin
      rx_data = DATA_W'(i); rx_valid = 1'b1; rx_exp.push_back(32'(i));
      cycle();
    end
    rx_valid = 1'b0;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_full got=%b exp=0", rx_ready); end
    for (int i = 0; i < 16; i++) begin
      avs_rd(3'd1, rd);
      exp = rx_exp.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL rx_read_%0d got=%h exp=%h", i, rd, exp); end
    end
    avs_rd(3'd1, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rx_underflow_data got=%h exp=0", rd); end
    avs_rd(3'd2, rd);
    checks++; if (rd !== 32'h6A) begin errors++; $display("FAIL rx_udf_status got=%h exp=0000006a", rd); end
    avs_wr(3'd2, 32'h20);
    avs_rd(3'd2, rd);
    checks++; if (rd !== 32'h0A) begin errors++; $display("FAIL rx_udf_clear got=%h exp=0000000a", rd); end
  endtask

  task automatic test_irq_thresh();
    logic [31:0] rd, exp;
    avs_wr(3'd5, 32'd4);
    avs_wr(3'd4, 32'h1);
    for (int i = 0; i < 3; i++) begin
      rx_data = DATA_W'(32'hC0 + 32'(i)); rx_valid = 1'b1; rx_exp.push_back(32'hC0 + 32'(i));
      cycle();
    end
    rx_valid = 1'b0;
    cycle(); cycle();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_below_thresh got=%b exp=0", irq); end
    rx_data = DATA_W'(32'hC3); rx_valid = 1'b1; rx_exp.push_back(32'hC3);
    cycle();
    rx_valid = 1'b0;
    cycle();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_thresh got=%b exp=1", irq); end
    avs_rd(3'd1, rd);
    exp = rx_exp.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL irq_read_data got=%h exp=%h", rd, exp); end
    cycle();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_read got=%b exp=0", irq); end
    while (rx_exp.size() > 0) begin
      avs_rd(3'd1, rd);
      exp = rx_exp.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL irq_drain got=%h exp=%h", rd, exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx_data = DATA_W'(i); rx_valid = 1'b1;
      avs_wr(3'd0, 32'(i));
    end
    rx_valid = 1'b0;
    cycle();
    checks++; if (irq !== 1'b1 || tx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset irq=%b tx_valid=%b exp 1 1", irq, tx_valid); end
    reset_reset_n = 1'b0;
    #2;
    checks++; if (irq !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL async_reset irq=%b tx_valid=%b rx_ready=%b exp 0 0 1", irq, tx_valid, rx_ready); end
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    cycle();
    avs_rd(3'd3, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mid_level got=%h exp=0", rd); end
    avs_rd(3'd4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mid_ctrl got=%h exp=0", rd); end
  endtask

  initial begin
    #12 reset_reset_n = 1'b1;
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_full_pushpop_flush();
    test_rx_fill();
    test_irq_thresh();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
